// File: rtl/rs_excite_driver_if.sv
// ---------------------------------------------------------------------------
// rs_excite_driver_if
//
// Request channel into rs_excite_driver: the control side offers a target
// bit vector with a valid/ready handshake. A transfer happens on a rising
// clock edge where req_valid and req_ready are both high.
//
// Signals:
//   req_valid  (master -> slave)  target request present
//   req_ready  (slave -> master)  driver can accept a request
//   req_target (master -> slave)  desired Q per lane, W bits
//
// Modports:
//   master : the control logic issuing targets
//   slave  : the driver consuming them
// ---------------------------------------------------------------------------
interface rs_excite_driver_if #(
    parameter int W = 4
) ();

    logic           req_valid;
    logic           req_ready;
    logic [W-1:0]   req_target;

    modport master (
        output req_valid,
        output req_target,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_target,
        output req_ready
    );

endinterface

// File: rtl/rs_excite_driver.sv
// ---------------------------------------------------------------------------
// rs_excite_driver
//
// Write-side driver for a bank of clocked RS flip-flops. A target vector is
// accepted over the request interface; per-lane S/R excitation is derived
// from the flops' Q feedback sampled at the accept edge, held for
// PULSE_CYCLES, followed by SETTLE_CYCLES of S=R=0, then a single CHECK
// cycle pulses done and (optionally) reports which lanes disagree with the
// target.
//
// Parameters:
//   W              number of RS flop lanes (>=1)
//   PULSE_CYCLES   cycles S/R are held asserted (>=1)
//   SETTLE_CYCLES  cycles of S=R=0 before the feedback check (>=0)
//
// Ports:
//   clock          system clock, all logic on posedge
//   reset          synchronous, active-high reset
//   req            request interface (slave): req_valid/req_ready/req_target
//   q_fb           Q feedback from the RS flop bank
//   S, R           per-lane set/reset excitation (never both high on a lane)
//   busy           high whenever the driver is not idle
//   done           one-cycle pulse at the end of each request
//   mismatch       OR of mismatch_mask
//   mismatch_mask  per-lane q_fb != target, captured entering CHECK
//
// Build option:
//   RS_FB_CHECK_EN  when defined, the CHECK cycle compares q_fb to the
//                   stored target. When undefined, mismatch/mismatch_mask
//                   are tied to 0 and q_fb only feeds the excitation logic.
//                   done timing is identical in both builds.
//
// Timing (accept on edge k):
//   S/R visible in cycles k+1 .. k+PULSE_CYCLES
//   done in cycle k+PULSE_CYCLES+SETTLE_CYCLES+1 (k+1 if no lane changes)
//   req_ready high again the cycle after done
// ---------------------------------------------------------------------------
module rs_excite_driver #(
    parameter int W             = 4,
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    rs_excite_driver_if.slave     req,
    input  logic [W-1:0]          q_fb,
    output logic [W-1:0]          S,
    output logic [W-1:0]          R,
    output logic                  busy,
    output logic                  done,
    output logic                  mismatch,
    output logic [W-1:0]          mismatch_mask
);

    // -----------------------------------------------------------------------
    // State encoding and counter sizing
    // -----------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_CHECK  = 2'd3;

    localparam int CNT_MAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    // The counter holds "cycles remaining minus one" so that a zero value
    // means this is the last cycle of the phase.
    localparam logic [CW-1:0] PULSE_LOAD  = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [1:0]     r_state;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_s;
    logic [W-1:0]   r_r;
    logic           r_busy;
    logic           r_done;

    // -----------------------------------------------------------------------
    // Combinational signals
    // -----------------------------------------------------------------------
    logic [1:0]     w_state_next;
    logic [CW-1:0]  w_cnt_next;
    logic           w_accept;
    logic [W-1:0]   w_set;
    logic [W-1:0]   w_rst;
    logic           w_need_drive;

    // -----------------------------------------------------------------------
    // Per-lane excitation from current Q and requested target.
    // Set only lanes that are 0 and must become 1; reset only lanes that are
    // 1 and must become 0. The two terms are mutually exclusive by
    // construction, so S&R can never be 1 on a lane.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_lane
            assign w_set[gi] = ~q_fb[gi] &  req.req_target[gi];
            assign w_rst[gi] =  q_fb[gi] & ~req.req_target[gi];
        end
    endgenerate

    assign w_need_drive = |(w_set | w_rst);

    // Ready is the only combinational output; it is forced low while reset
    // is asserted so nothing can be accepted during the reset cycle.
    assign req.req_ready = (r_state == ST_IDLE) && !reset;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (req.req_valid) begin
                    w_accept = 1'b1;
                    if (w_need_drive) begin
                        w_state_next = ST_DRIVE;
                        w_cnt_next   = PULSE_LOAD;
                    end else begin
                        // Nothing to flip: go straight to the check cycle.
                        w_state_next = ST_CHECK;
                        w_cnt_next   = '0;
                    end
                end
            end

            ST_DRIVE: begin
                if (r_cnt == '0) begin
                    if (SETTLE_CYCLES == 0) begin
                        w_state_next = ST_CHECK;
                        w_cnt_next   = '0;
                    end else begin
                        w_state_next = ST_SETTLE;
                        w_cnt_next   = SETTLE_LOAD;
                    end
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end

            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_CHECK;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end

            ST_CHECK: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end

            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State, counter and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_s     <= '0;
            r_r     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_busy  <= (w_state_next != ST_IDLE);
            // CHECK lasts exactly one cycle, so this yields a single pulse.
            r_done  <= (w_state_next == ST_CHECK);

            // Excitation is loaded once at accept and held unchanged for the
            // whole DRIVE phase; it drops to zero as soon as DRIVE is left.
            if (w_accept && w_need_drive) begin
                r_s <= w_set;
                r_r <= w_rst;
            end else if (w_state_next != ST_DRIVE) begin
                r_s <= '0;
                r_r <= '0;
            end
        end
    end

    assign S    = r_s;
    assign R    = r_r;
    assign busy = r_busy;
    assign done = r_done;

    // -----------------------------------------------------------------------
    // Feedback comparison
    // -----------------------------------------------------------------------
`ifdef RS_FB_CHECK_EN
    logic [W-1:0]   r_target;
    logic [W-1:0]   r_mask;
    logic [W-1:0]   w_cmp_target;

    // A no-change request enters CHECK on the accept edge itself, before
    // r_target has been written, so compare against the incoming target.
    assign w_cmp_target = w_accept ? req.req_target : r_target;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_target <= '0;
            r_mask   <= '0;
        end else begin
            if (w_accept) begin
                r_target <= req.req_target;
            end

            // Captured together with done so both are visible in the same
            // cycle; held afterwards until the next accept clears it.
            if (w_state_next == ST_CHECK) begin
                r_mask <= q_fb ^ w_cmp_target;
            end else if (w_accept) begin
                r_mask <= '0;
            end
        end
    end

    assign mismatch_mask = r_mask;
    assign mismatch      = |r_mask;
`else
    assign mismatch_mask = '0;
    assign mismatch      = 1'b0;
`endif

endmodule

// File: tb/tb_rs_excite_driver.sv
// ---------------------------------------------------------------------------
// tb_rs_excite_driver
//
// Self-checking bench for rs_excite_driver (W=4, PULSE=2, SETTLE=1).
// Expected behaviour comes from a request-level model: for each request the
// bench works out the set/reset vectors, the done latency and the expected
// mismatch mask from the target and the feedback values, then checks every
// cycle of the request against that timeline. Directed scenarios come first,
// followed by randomized requests.
// ---------------------------------------------------------------------------
module tb_rs_excite_driver;

    localparam int W  = 4;
    localparam int P  = 2;
    localparam int SS = 1;

`ifdef RS_FB_CHECK_EN
    localparam bit FB_EN = 1'b1;
`else
    localparam bit FB_EN = 1'b0;
`endif

    logic           clock;
    logic           reset;
    logic [W-1:0]   q_fb;
    logic [W-1:0]   S;
    logic [W-1:0]   R;
    logic           busy;
    logic           done;
    logic           mismatch;
    logic [W-1:0]   mismatch_mask;

    rs_excite_driver_if #(.W(W)) rif ();

    rs_excite_driver #(
        .W             (W),
        .PULSE_CYCLES  (P),
        .SETTLE_CYCLES (SS)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req           (rif),
        .q_fb          (q_fb),
        .S             (S),
        .R             (R),
        .busy          (busy),
        .done          (done),
        .mismatch      (mismatch),
        .mismatch_mask (mismatch_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int           checks;
    int           errors;
    logic [W-1:0] last_mask;   // mask the model expects to be held in IDLE

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full request. Called #1 after a posedge while the DUT is idle.
    // q     : feedback at the accept edge
    // t     : target offered
    // qchk  : feedback the "flops" present after the pulse (ignored when no
    //         lane needs to change, since then the check happens at accept)
    // keep  : keep req_valid high and scramble req_target while busy
    task automatic do_req(input logic [W-1:0] q, input logic [W-1:0] t,
                          input logic [W-1:0] qchk, input bit keep);
        logic [W-1:0] exp_s;
        logic [W-1:0] exp_r;
        logic [W-1:0] exp_mask;
        bit           change;
        int           lat;

        exp_s    = ~q & t;
        exp_r    = q & ~t;
        change   = (exp_s | exp_r) != '0;
        lat      = change ? (P + SS + 1) : 1;
        exp_mask = FB_EN ? ((change ? qchk : q) ^ t) : '0;

        chk("ready_before_accept", {31'd0, rif.req_ready}, 32'd1);
        chk("mask_held_idle", {28'd0, mismatch_mask}, {28'd0, last_mask});

        q_fb           = q;
        rif.req_valid  = 1'b1;
        rif.req_target = t;

        for (int c = 1; c <= lat; c++) begin
            tick();
            if (c == 1) begin
                if (!keep) rif.req_valid = 1'b0;
                if (change) q_fb = qchk;
            end
            if (keep) rif.req_target = W'($urandom);

            chk("s_out", {28'd0, S}, (c <= P && change) ? {28'd0, exp_s} : 32'd0);
            chk("r_out", {28'd0, R}, (c <= P && change) ? {28'd0, exp_r} : 32'd0);
            chk("s_and_r", {28'd0, S & R}, 32'd0);
            chk("busy_active", {31'd0, busy}, 32'd1);
            chk("ready_busy", {31'd0, rif.req_ready}, 32'd0);
            chk("done_pulse", {31'd0, done}, (c == lat) ? 32'd1 : 32'd0);
            if (c == lat) begin
                chk("mask_at_done", {28'd0, mismatch_mask}, {28'd0, exp_mask});
                chk("mismatch_at_done", {31'd0, mismatch}, {31'd0, |exp_mask});
            end else begin
                chk("mask_cleared", {28'd0, mismatch_mask}, 32'd0);
            end
        end

        // Back in IDLE: the next accept can happen on the coming edge.
        tick();
        last_mask = exp_mask;
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("done_low", {31'd0, done}, 32'd0);
        chk("s_idle", {28'd0, S | R}, 32'd0);
        $display("req q=%b t=%b qchk=%b keep=%0d lat=%0d mask=%b",
                 q, t, qchk, keep, lat, mismatch_mask);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        last_mask      = '0;
        reset          = 1'b1;
        rif.req_valid  = 1'b0;
        rif.req_target = '0;
        q_fb           = '0;

        // ---- Reset state ----
        tick();
        tick();
        chk("rst_ready", {31'd0, rif.req_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sr", {28'd0, S | R}, 32'd0);
        chk("rst_mask", {28'd0, mismatch_mask}, 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", {31'd0, rif.req_ready}, 32'd1);

        // ---- 1: set two lanes, flops respond ----
        do_req(4'b0000, 4'b1010, 4'b1010, 1'b0);
        // ---- 2: mixed set and reset ----
        do_req(4'b1100, 4'b0110, 4'b0110, 1'b0);
        // ---- 3: no change needed ----
        do_req(4'b0101, 4'b0101, 4'b0101, 1'b0);
        // ---- 4: flops never respond -> full mask, then cleared by next ----
        do_req(4'b0000, 4'b1111, 4'b0000, 1'b0);
        do_req(4'b1111, 4'b1111, 4'b1111, 1'b0);

        // ---- 5: reset during DRIVE cycle 1 ----
        q_fb           = 4'b0011;
        rif.req_valid  = 1'b1;
        rif.req_target = 4'b1100;
        tick();
        rif.req_valid = 1'b0;
        chk("abort_s_drive", {28'd0, S}, 32'hC);
        chk("abort_r_drive", {28'd0, R}, 32'h3);
        reset = 1'b1;
        tick();
        chk("abort_sr_zero", {28'd0, S | R}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_ready_in_rst", {31'd0, rif.req_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("abort_ready", {31'd0, rif.req_ready}, 32'd1);
        last_mask = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("abort_no_done", {31'd0, done}, 32'd0);
            chk("abort_stay_idle", {31'd0, busy}, 32'd0);
        end

        // ---- 6: valid held high, targets scrambled while busy ----
        do_req(4'b0000, 4'b0001, 4'b0001, 1'b1);
        do_req(4'b0001, 4'b1000, 4'b1001, 1'b1);
        do_req(4'b1001, 4'b1001, 4'b1001, 1'b1);
        do_req(4'b1001, 4'b0110, 4'b0110, 1'b0);

        // ---- Randomized requests ----
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] rq;
            logic [W-1:0] rt;
            logic [W-1:0] rc;
            bit           rk;
            int           gap;
            rq  = W'($urandom);
            rt  = W'($urandom);
            rc  = ($urandom_range(0, 1) == 1) ? rt : W'($urandom);
            rk  = ($urandom_range(0, 2) == 0);
            gap = $urandom_range(0, 2);
            if (!rk && gap > 0) begin
                rif.req_valid = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    tick();
                    chk("gap_ready", {31'd0, rif.req_ready}, 32'd1);
                    chk("gap_done", {31'd0, done}, 32'd0);
                end
            end
            do_req(rq, rt, rc, rk);
        end

        rif.req_valid = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
